// File: rtl/conv_addr_sequencer_pkg.sv
// Shared types and helpers for the convolution read/write address sequencer.
package conv_addr_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StScan   = 2'b01,
        StChNext = 2'b10,
        StDone   = 2'b11
    } seq_state_e;

    localparam logic [1:0] StrideOne = 2'd1;
    localparam logic [1:0] StrideTwo = 2'd2;

    function automatic logic cfg_legal(input int unsigned map_size, input int unsigned kernel,
                                       input int unsigned stride, input int unsigned num_ch);
        return (kernel != 0) && (kernel <= map_size) &&
               ((stride == 32'(StrideOne)) || (stride == 32'(StrideTwo))) && (num_ch != 0);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster row/column position of the current read beat, plus the output-window qualifier
// for a KxK window at stride 1 or 2.
module conv_pos_counter
    import conv_addr_sequencer_pkg::*;
#(
    parameter int unsigned DIM_WIDTH = 6,
    parameter int unsigned KER_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 adv,
    input  logic [DIM_WIDTH-1:0] map_size,
    input  logic [KER_WIDTH-1:0] kernel,
    input  logic [1:0]           stride,
    output logic [DIM_WIDTH-1:0] row,
    output logic [DIM_WIDTH-1:0] col,
    output logic                 map_end,
    output logic                 win
);

    logic [DIM_WIDTH-1:0] row_q, row_d, col_q, col_d;
    logic [DIM_WIDTH-1:0] last_idx, km1, row_off, col_off;
    logic                 row_end;

    always_comb begin
        last_idx = map_size - DIM_WIDTH'(1);
        km1      = DIM_WIDTH'(kernel) - DIM_WIDTH'(1);
        row_end  = (col_q == last_idx);
        map_end  = row_end && (row_q == last_idx);
        row_off  = row_q - km1;
        col_off  = col_q - km1;
        // Stride is 1 or 2 once latched, so "mod stride == 0" reduces to an LSB test.
        win      = (row_q >= km1) && (col_q >= km1) &&
                   ((stride == StrideOne) || (!row_off[0] && !col_off[0]));
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (row_end) begin
                col_d = '0;
                row_d = row_q + DIM_WIDTH'(1);
            end else begin
                col_d = col_q + DIM_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/conv_addr_sequencer.sv
// Raster-order read address generator for square feature-map channels; flags beats that
// complete a convolution window and issues a contiguous write address for each one.
module conv_addr_sequencer
    import conv_addr_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DIM_WIDTH  = 6,
    parameter int unsigned KER_WIDTH  = 3,
    parameter int unsigned CH_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_map_size,
    input  logic [KER_WIDTH-1:0]  cfg_kernel,
    input  logic [1:0]            cfg_stride,
    input  logic [CH_WIDTH-1:0]   cfg_num_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_rd_base,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_base,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic                  win_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DIM_WIDTH-1:0]  row_out,
    output logic [DIM_WIDTH-1:0]  col_out,
    output logic [CH_WIDTH-1:0]   ch_out,
    output logic [1:0]            state_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    seq_state_e            state_q, state_d;
    logic [DIM_WIDTH-1:0]  map_q, map_d;
    logic [KER_WIDTH-1:0]  ker_q, ker_d;
    logic [1:0]            stride_q, stride_d;
    logic [CH_WIDTH-1:0]   nch_q, nch_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  err_q, err_d;

    logic pos_clr, pos_adv, map_end, win, beat, legal;

    conv_pos_counter #(
        .DIM_WIDTH (DIM_WIDTH),
        .KER_WIDTH (KER_WIDTH)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pos_clr),
        .adv      (pos_adv),
        .map_size (map_q),
        .kernel   (ker_q),
        .stride   (stride_q),
        .row      (row_out),
        .col      (col_out),
        .map_end  (map_end),
        .win      (win)
    );

    assign legal = cfg_legal(32'(cfg_map_size), 32'(cfg_kernel), 32'(cfg_stride),
                             32'(cfg_num_ch));
    assign beat  = (state_q == StScan) && rd_ready;

    always_comb begin
        state_d   = state_q;
        map_d     = map_q;
        ker_d     = ker_q;
        stride_d  = stride_q;
        nch_d     = nch_q;
        ch_d      = ch_q;
        base_d    = base_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        err_d     = err_q;
        pos_clr   = 1'b0;
        pos_adv   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    map_d    = cfg_map_size;
                    ker_d    = cfg_kernel;
                    stride_d = cfg_stride;
                    nch_d    = cfg_num_ch;
                    err_d    = !legal;
                    if (legal) begin
                        state_d   = StScan;
                        base_d    = cfg_rd_base;
                        rd_addr_d = cfg_rd_base;
                        wr_addr_d = cfg_wr_base;
                        ch_d      = '0;
                        pos_clr   = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StScan: begin
                if (beat) begin
                    pos_adv   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    if (win) wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
                    if (map_end) begin
                        state_d = (ch_q == nch_q - CH_WIDTH'(1)) ? StDone : StChNext;
                    end
                end
            end
            StChNext: begin
                // rd_addr has already stepped S*S beats past the old base: it is the new base.
                base_d    = rd_addr_q;
                rd_addr_d = rd_addr_q;
                ch_d      = ch_q + CH_WIDTH'(1);
                pos_clr   = 1'b1;
                state_d   = StScan;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            map_q     <= '0;
            ker_q     <= '0;
            stride_q  <= '0;
            nch_q     <= '0;
            ch_q      <= '0;
            base_q    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            map_q     <= map_d;
            ker_q     <= ker_d;
            stride_q  <= stride_d;
            nch_q     <= nch_d;
            ch_q      <= ch_d;
            base_q    <= base_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            err_q     <= err_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign wr_addr   = wr_addr_q;
    assign ch_out    = ch_q;
    assign rd_valid  = (state_q == StScan);
    assign win_valid = rd_valid && win;
    assign state_out = state_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Directed bench for conv_addr_sequencer: raster scans, multi-channel, backpressure,
// illegal configuration and mid-scan reset.
module tb_conv_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cfg_map_size = '0;
    logic [2:0]  cfg_kernel = '0;
    logic [1:0]  cfg_stride = '0;
    logic [3:0]  cfg_num_ch = '0;
    logic [10:0] cfg_rd_base = '0;
    logic [10:0] cfg_wr_base = '0;
    logic        rd_ready = 1'b1;
    logic [10:0] rd_addr, wr_addr;
    logic        rd_valid, win_valid, busy, done, cfg_err;
    logic [5:0]  row_out, col_out;
    logic [3:0]  ch_out;
    logic [1:0]  state_out;

    conv_addr_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_map_size (cfg_map_size),
        .cfg_kernel   (cfg_kernel),
        .cfg_stride   (cfg_stride),
        .cfg_num_ch   (cfg_num_ch),
        .cfg_rd_base  (cfg_rd_base),
        .cfg_wr_base  (cfg_wr_base),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .win_valid    (win_valid),
        .wr_addr      (wr_addr),
        .row_out      (row_out),
        .col_out      (col_out),
        .ch_out       (ch_out),
        .state_out    (state_out),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scan statistics gathered by run_scan.
    int cur_s, cur_k, cur_st, cur_wrb;
    int beats, wins, bubbles, seq_err, pos_err, win_err, wr_err, bp_err;
    int first_beat_cyc, last_beat_cyc, done_cyc, first_win_rd, first_win_row, first_win_col;
    int last_wr, last_rd;
    int ch_start[16];
    bit got_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input int s, input int k, input int st, input int c,
                          input int rdb, input int wrb);
        cfg_map_size = 6'(s);
        cfg_kernel   = 3'(k);
        cfg_stride   = 2'(st);
        cfg_num_ch   = 4'(c);
        cfg_rd_base  = 11'(rdb);
        cfg_wr_base  = 11'(wrb);
        cur_s = s; cur_k = k; cur_st = st; cur_wrb = wrb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows a scan from the first beat to the done pulse, checking it against a
    // row/col/window model; optionally stalls rd_ready for 3 cycles at row 5, col 7.
    task automatic run_scan(input int budget, input bit bp);
        int exp_row = 0, exp_col = 0, exp_ch = 0, exp_wr = cur_wrb;
        int prev_rd = 0;
        bit have_prev = 0, bp_done = 0, exp_win;
        logic [10:0] s_rd, s_wr;
        logic [5:0]  s_row, s_col;
        logic        s_win;
        beats = 0; wins = 0; bubbles = 0; seq_err = 0; pos_err = 0; win_err = 0;
        wr_err = 0; bp_err = 0; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        first_win_rd = -1; first_win_row = -1; first_win_col = -1; last_wr = -1;
        last_rd = -1; got_done = 0;
        for (int i = 0; i < 16; i++) ch_start[i] = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                break;
            end
            if (bp && !bp_done && rd_valid && row_out == 6'd5 && col_out == 6'd7) begin
                s_rd = rd_addr; s_wr = wr_addr; s_row = row_out; s_col = col_out;
                s_win = win_valid;
                rd_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    cyc++;
                    if (rd_addr !== s_rd || wr_addr !== s_wr || row_out !== s_row ||
                        col_out !== s_col || win_valid !== s_win || rd_valid !== 1'b1)
                        bp_err++;
                end
                rd_ready = 1'b1;
                bp_done = 1;
            end
            if (rd_valid) begin
                if (beats == 0) first_beat_cyc = cyc;
                if (row_out == 6'd0 && col_out == 6'd0) ch_start[ch_out] = int'(rd_addr);
                if (have_prev && int'(rd_addr) != (prev_rd + 1) % 2048) seq_err++;
                if (int'(row_out) != exp_row || int'(col_out) != exp_col ||
                    int'(ch_out) != exp_ch) pos_err++;
                exp_win = (exp_row >= cur_k - 1) && (exp_col >= cur_k - 1) &&
                          ((exp_row - (cur_k - 1)) % cur_st == 0) &&
                          ((exp_col - (cur_k - 1)) % cur_st == 0);
                if (win_valid !== exp_win) win_err++;
                if (win_valid === 1'b1) begin
                    if (wins == 0) begin
                        first_win_rd  = int'(rd_addr);
                        first_win_row = int'(row_out);
                        first_win_col = int'(col_out);
                    end
                    if (int'(wr_addr) != exp_wr) wr_err++;
                    exp_wr  = (exp_wr + 1) % 2048;
                    last_wr = int'(wr_addr);
                    wins++;
                end
                prev_rd = int'(rd_addr);
                have_prev = 1;
                last_rd = int'(rd_addr);
                last_beat_cyc = cyc;
                beats++;
                exp_col++;
                if (exp_col == cur_s) begin
                    exp_col = 0;
                    exp_row++;
                end
            end else if (busy) begin
                bubbles++;
                exp_ch++;
                exp_row = 0;
                exp_col = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_scan_clean(input string tag);
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        chk({tag, "_done_latency"}, 32'(done_cyc), 32'(last_beat_cyc + 1));
        chk({tag, "_seq_err"}, 32'(seq_err), 0);
        chk({tag, "_pos_err"}, 32'(pos_err), 0);
        chk({tag, "_win_err"}, 32'(win_err), 0);
        chk({tag, "_wr_err"}, 32'(wr_err), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state_out), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_rvwv"}, 32'({rd_valid, win_valid}), 0);
        chk({tag, "_rowcolch"}, 32'({row_out, col_out, ch_out}), 0);
        chk({tag, "_busy_done_err"}, 32'({busy, done, cfg_err}), 0);
    endtask

    initial begin
        // Power-on reset.
        repeat (2) @(negedge clk);
        chk_all_zero("por");
        rst_n = 1'b1;
        @(negedge clk);

        // S=32, K=5, stride 1, one channel.
        launch(32, 5, 1, 1, 174, 0);
        run_scan(2000, 0);
        chk_scan_clean("t1");
        chk("t1_first_beat_cyc", 32'(first_beat_cyc), 0);
        chk("t1_first_rd", 32'(ch_start[0]), 174);
        chk("t1_first_win_rd", 32'(first_win_rd), 306);
        chk("t1_first_win_pos", 32'(first_win_row * 64 + first_win_col), 4 * 64 + 4);
        chk("t1_wins", 32'(wins), 784);
        chk("t1_last_wr", 32'(last_wr), 783);
        chk("t1_last_rd", 32'(last_rd), 1197);
        chk("t1_done_pulse", 32'(done), 1);
        @(negedge clk);
        chk("t1_idle_state", 32'(state_out), 0);
        chk("t1_idle_busy_done", 32'({busy, done}), 0);

        // S=28, K=2, stride 2: outputs only at odd row and odd column.
        launch(28, 2, 2, 1, 100, 0);
        run_scan(2000, 0);
        chk_scan_clean("t2");
        chk("t2_wins", 32'(wins), 196);
        chk("t2_first_win_rd", 32'(first_win_rd), 129);
        chk("t2_last_wr", 32'(last_wr), 195);
        // Start raised during the done cycle must be dropped.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_start_in_done_state", 32'(state_out), 0);
        chk("t2_start_in_done_rv", 32'(rd_valid), 0);

        // Three channels with bubbles between them.
        launch(10, 5, 1, 3, 86, 500);
        run_scan(1000, 0);
        chk_scan_clean("t3");
        chk("t3_ch0_base", 32'(ch_start[0]), 86);
        chk("t3_ch1_base", 32'(ch_start[1]), 186);
        chk("t3_ch2_base", 32'(ch_start[2]), 286);
        chk("t3_bubbles", 32'(bubbles), 2);
        chk("t3_wins", 32'(wins), 108);
        chk("t3_first_win_rd", 32'(first_win_rd), 130);
        chk("t3_last_wr", 32'(last_wr), 607);
        chk("t3_last_rd", 32'(last_rd), 385);
        @(negedge clk);

        // Backpressure at row 5, col 7.
        launch(10, 3, 1, 1, 0, 0);
        run_scan(500, 1);
        chk_scan_clean("t4");
        chk("t4_bp_stable", 32'(bp_err), 0);
        chk("t4_beats", 32'(beats), 100);
        chk("t4_wins", 32'(wins), 64);
        chk("t4_last_wr", 32'(last_wr), 63);
        @(negedge clk);

        // Illegal config K > S.
        launch(5, 6, 1, 1, 0, 0);
        chk("t5_state_done", 32'(state_out), 3);
        chk("t5_done", 32'(done), 1);
        chk("t5_cfg_err", 32'(cfg_err), 1);
        chk("t5_rv_a", 32'(rd_valid), 0);
        @(negedge clk);
        chk("t5_state_idle", 32'(state_out), 0);
        chk("t5_done_low", 32'(done), 0);
        chk("t5_cfg_err_sticky", 32'(cfg_err), 1);
        chk("t5_rv_b", 32'(rd_valid), 0);
        launch(4, 2, 1, 1, 20, 40);
        chk("t5_cfg_err_cleared", 32'(cfg_err), 0);
        chk("t5_legal_first_rd", 32'(rd_addr), 20);
        run_scan(100, 0);
        chk_scan_clean("t5");
        chk("t5_wins", 32'(wins), 9);
        chk("t5_last_wr", 32'(last_wr), 48);
        @(negedge clk);

        // Reset during channel 1, then rescan.
        launch(10, 5, 1, 3, 86, 500);
        begin
            bit found = 0;
            for (int i = 0; i < 400; i++) begin
                if (rd_valid && ch_out == 4'd1 && row_out == 6'd2) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            chk("t6_reached_ch1", 32'(found), 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("t6_rst");
        launch(10, 5, 1, 3, 86, 500);
        chk("t6_rescan_rd", 32'(rd_addr), 86);
        chk("t6_rescan_pos", 32'({ch_out, row_out, col_out}), 0);
        run_scan(1000, 0);
        chk_scan_clean("t6");
        chk("t6_wins", 32'(wins), 108);
        chk("t6_last_wr", 32'(last_wr), 607);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
